// File: rtl/pwm_zone_scanner_pkg.sv
// pwm_zone_scanner_pkg: shared sizes, zone/segment encodings and commit FSM state
package pwm_zone_scanner_pkg;
  localparam int NUM_DIGITS      = 8;
  localparam int ZONES_PER_DIGIT = 3;
  localparam int NUM_ZONES       = NUM_DIGITS * ZONES_PER_DIGIT;
  typedef enum logic [1:0] {ZONE_L, ZONE_M, ZONE_R} zone_e;
  localparam int SEG_A  = 0;
  localparam int SEG_B  = 1;
  localparam int SEG_C  = 2;
  localparam int SEG_D  = 3;
  localparam int SEG_E  = 4;
  localparam int SEG_F  = 5;
  localparam int SEG_G  = 6;
  localparam int SEG_DP = 7;
  typedef enum logic {ST_IDLE, ST_PEND} commit_st_e;
endpackage

// File: rtl/pwm_zone_scanner_cmp.sv
// zone_pwm_cmp: one zone's PWM compare; GAMMA_EN selects a squared level curve
module zone_pwm_cmp (
  input  logic [7:0] level,
  input  logic [7:0] p,
  input  logic       blank,
  output logic       lit
);
  logic [7:0] eff;
`ifdef GAMMA_EN
  logic [15:0] sq;
  always_comb begin
    sq  = 16'(level) * 16'(level);
    eff = &level ? 8'hFF : sq[15:8];
  end
`else
  always_comb eff = level;
`endif
  always_comb lit = !blank && p < eff;
endmodule

// File: rtl/pwm_zone_scanner.sv
// pwm_zone_scanner: shadow/active 24-zone frames driving a PWM-dimmed 8-digit 7-seg scan
// GAMMA_EN (in zone_pwm_cmp) enables gamma-mapped levels
module pwm_zone_scanner
  import pwm_zone_scanner_pkg::*;
#(
  parameter int PWM_DIV = 1,
  parameter int BLANK   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [4:0] wr_zone,
  input  logic [7:0] wr_level,
  output logic       wr_err,
  input  logic       commit,
  output logic       commit_busy,
  output logic       frame_start,
  output logic [7:0] sseg,
  output logic [7:0] digit
);
  localparam int SLOT = BLANK + 256 * PWM_DIV;
  localparam int SW   = $clog2(SLOT);
  localparam int DW   = PWM_DIV > 1 ? $clog2(PWM_DIV) : 1;
  commit_st_e    st_q, st_d;
  logic [SW-1:0] s_q, s_d;
  logic [DW-1:0] div_q, div_d;
  logic [7:0]    p_q, p_d;
  logic [2:0]    d_q, d_d;
  logic [7:0]    shadow_q [NUM_ZONES];
  logic [7:0]    shadow_d [NUM_ZONES];
  logic [7:0]    active_q [NUM_ZONES];
  logic [7:0]    active_d [NUM_ZONES];
  logic [7:0]    sseg_q, sseg_d, digit_q, digit_d, seg;
  logic          wr_err_q, wr_err_d, frame_start_q, frame_start_d;
  logic          slot_end, blank, div_wrap, copy, wr_fire;
  logic [4:0]    base;
  logic [2:0]    lit;
  always_comb begin
    slot_end = s_q == SW'(SLOT - 1);
    blank    = s_q < SW'(BLANK);
    div_wrap = div_q == DW'(PWM_DIV - 1);
    s_d      = slot_end ? '0 : s_q + SW'(1);
    d_d      = slot_end ? d_q + 3'd1 : d_q;
    div_d    = blank || slot_end || div_wrap ? '0 : div_q + DW'(1);
    p_d      = blank || slot_end ? '0 : p_q + 8'(div_wrap);
    base     = 5'(d_q) * 5'(ZONES_PER_DIGIT);
    wr_fire  = wr_valid && st_q == ST_IDLE;
    // the copy lands on digit 7's last clock so the next frame starts clean
    copy     = st_q == ST_PEND && slot_end && d_q == 3'(NUM_DIGITS - 1);
    st_d     = copy ? ST_IDLE : commit ? ST_PEND : st_q;
    shadow_d = shadow_q;
    if (wr_fire && wr_zone < 5'(NUM_ZONES)) shadow_d[wr_zone] = wr_level;
    active_d = active_q;
    if (copy) active_d = shadow_q;
  end
  for (genvar k = 0; k < ZONES_PER_DIGIT; k++) begin : g_zone
    zone_pwm_cmp u_cmp (
      .level(active_q[base + 5'(k)]),
      .p    (p_q),
      .blank(blank),
      .lit  (lit[k])
    );
  end
  always_comb begin
    seg           = '0;
    seg[SEG_A]    = lit[ZONE_M];
    seg[SEG_B]    = lit[ZONE_R];
    seg[SEG_C]    = lit[ZONE_R];
    seg[SEG_D]    = lit[ZONE_M];
    seg[SEG_E]    = lit[ZONE_L];
    seg[SEG_F]    = lit[ZONE_L];
    seg[SEG_G]    = lit[ZONE_M];
    sseg_d        = ~seg;
    digit_d       = ~(8'd1 << d_q);
    frame_start_d = d_q == 3'd0 && s_q == '0;
    wr_err_d      = wr_fire && wr_zone >= 5'(NUM_ZONES);
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      st_q          <= ST_IDLE;
      s_q           <= '0;
      div_q         <= '0;
      p_q           <= '0;
      d_q           <= '0;
      shadow_q      <= '{default: '0};
      active_q      <= '{default: '0};
      sseg_q        <= 8'hFF;
      digit_q       <= 8'hFF;
      wr_err_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      st_q          <= st_d;
      s_q           <= s_d;
      div_q         <= div_d;
      p_q           <= p_d;
      d_q           <= d_d;
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      sseg_q        <= sseg_d;
      digit_q       <= digit_d;
      wr_err_q      <= wr_err_d;
      frame_start_q <= frame_start_d;
    end
  assign wr_ready    = st_q == ST_IDLE;
  assign commit_busy = st_q == ST_PEND;
  assign wr_err      = wr_err_q;
  assign frame_start = frame_start_q;
  assign sseg        = sseg_q;
  assign digit       = digit_q;
endmodule

// File: tb/tb_pwm_zone_scanner.sv
// tb_pwm_zone_scanner: randomized bench; a slot-level frame model predicts each digit slot,
// a monitor measures every slot the DUT scans out and compares
module tb_pwm_zone_scanner;
  localparam int PWM_DIV = 1;
  localparam int BLANK   = 4;
  localparam int SLOT    = BLANK + 256 * PWM_DIV;
  localparam int FR      = 8 * SLOT;
  logic       clk = 0, reset = 1, wr_valid = 0, commit = 0;
  logic [4:0] wr_zone = 0;
  logic [7:0] wr_level = 0;
  logic       wr_ready, wr_err, commit_busy, frame_start;
  logic [7:0] sseg, digit;

  pwm_zone_scanner #(.PWM_DIV(PWM_DIV), .BLANK(BLANK)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_zone(wr_zone), .wr_level(wr_level), .wr_err(wr_err), .commit(commit),
    .commit_busy(commit_busy), .frame_start(frame_start), .sseg(sseg), .digit(digit)
  );

  always #5 clk = ~clk;

  typedef struct { int k; int img[24]; } pend_t;
  typedef struct { int dig; int lows[8]; int fs; } slot_t;
  pend_t pend_q[$];
  slot_t exp_q[$];
  int shadow_m[24], act_m[24];
  int cnt, last_e = -1, n_copies = 0, falls = 0, n_cmp = 0, n_bad = 0;
  // zone (0=l,1=m,2=r) lighting each sseg bit a..dp; -1 means never lit
  int seg_zone[8] = '{1, 2, 2, 1, 0, 0, 1, -1};

  // cnt equals the DUT's scan position (clocks since reset release)
  always @(posedge clk or negedge reset) cnt <= !reset ? 0 : cnt + 1;

  function automatic int eff(input int l);
`ifdef GAMMA_EN
    return l == 255 ? 255 : l * l / 256;
`else
    return l;
`endif
  endfunction

  function automatic int lvl();
    if ($urandom_range(0, 9) == 0) return 255;
    if ($urandom_range(0, 9) == 0) return 0;
    return int'($urandom_range(0, 255));
  endfunction

  task automatic chk(input string nm, input int a, input int e);
    n_cmp++;
    if (a != e) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, a, e, $time);
    end
  endtask

  // commit sampled at position q: the copy happens at the first frame end after q,
  // so the new image owns the frame that follows it
  task automatic model_commit(input int q);
    pend_t pe;
    if (last_e >= 0 && q <= last_e) return;
    pe.k = (q + 1) / FR + 1;
    pe.img = shadow_m;
    last_e = pe.k * FR - 1;
    pend_q.push_back(pe);
    n_copies++;
  endtask

  task automatic model_reset();
    shadow_m = '{default: 0};
    act_m = '{default: 0};
    pend_q.delete();
    exp_q.delete();
    last_e = -1;
  endtask

  // predictor: one expected record per slot, pushed shortly after the slot begins
  initial begin
    slot_t x;
    int j, k;
    forever begin
      @(negedge clk);
      if (reset && cnt % SLOT == 1) begin
        j = (cnt - 1) / SLOT % 8;
        k = (cnt - 1) / FR;
        while (pend_q.size() > 0 && pend_q[0].k <= k) begin
          act_m = pend_q[0].img;
          pend_q.delete(0);
        end
        x.dig = 255 ^ (1 << j);
        for (int b = 0; b < 8; b++)
          x.lows[b] = seg_zone[b] < 0 ? 0 : eff(act_m[3 * j + seg_zone[b]]) * PWM_DIV;
        x.fs = j == 0 ? 1 : 0;
        exp_q.push_back(x);
      end
    end
  end

  // monitor: a slot is a run of cycles with one digit value
  initial begin
    int len, cur, fs, bb;
    int lows[8];
    bit bp;
    slot_t x;
    len = 0;
    bp = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        len = 0;
        bp = 0;
      end else begin
        if (bp && !commit_busy) falls++;
        bp = commit_busy;
        if (len > 0 && int'(digit) != cur) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL slot_queue: slot digit=%0d seen, none predicted at %0t", cur, $time);
          end else begin
            x = exp_q.pop_front();
            chk("slot_digit", cur, x.dig);
            chk("slot_len", len, SLOT);
            chk("slot_frame_start", fs, x.fs);
            chk("slot_blank_dark", bb, 0);
            for (int b = 0; b < 8; b++) chk($sformatf("slot_seg%0d_low", b), lows[b], x.lows[b]);
          end
          len = 0;
        end
        if (len > 0 || digit != 8'hFF) begin
          if (len == 0) begin
            cur = int'(digit);
            fs = 0;
            bb = 0;
            lows = '{default: 0};
          end
          for (int b = 0; b < 8; b++) if (!sseg[b]) lows[b]++;
          if (frame_start) fs += len == 0 ? 1 : 100;
          if (len < BLANK && sseg != 8'hFF) bb++;
          len++;
        end
      end
    end
  end

  task automatic do_write(input int z, input int lv, input bit with_commit);
    int n = 0;
    @(negedge clk);
    while (!wr_ready && n < 3 * FR) begin @(negedge clk); n++; end
    chk("wr_ready_before_write", int'(wr_ready), 1);
    wr_valid = 1;
    wr_zone = 5'(z);
    wr_level = 8'(lv);
    commit = with_commit;
    if (z < 24) shadow_m[z] = lv;
    if (with_commit) model_commit(cnt);
    @(negedge clk);
    wr_valid = 0;
    commit = 0;
    chk("wr_err", int'(wr_err), z >= 24 ? 1 : 0);
    if (with_commit) begin
      chk("busy_after_commit", int'(commit_busy), 1);
      chk("ready_low_in_pend", int'(wr_ready), 0);
    end
    @(negedge clk);
    chk("wr_err_single_pulse", int'(wr_err), 0);
  endtask

  task automatic do_commit();
    @(negedge clk);
    commit = 1;
    model_commit(cnt);
    @(negedge clk);
    commit = 0;
    chk("busy_during_pend", int'(commit_busy), 1);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!wr_ready && n < 3 * FR) begin @(negedge clk); n++; end
    chk("ready_return_pos", cnt, last_e + 1);
    chk("busy_clear_after_copy", int'(commit_busy), 0);
  endtask

  // write offered during PEND; it must only be taken once the copy is done
  task automatic held_write(input int z, input int lv);
    int n = 0;
    @(negedge clk);
    wr_valid = 1;
    wr_zone = 5'(z);
    wr_level = 8'(lv);
    do begin @(negedge clk); n++; end while (!wr_ready && n < 3 * FR);
    chk("ready_return_pos", cnt, last_e + 1);
    if (z < 24) shadow_m[z] = lv;
    @(negedge clk);
    wr_valid = 0;
    chk("wr_err", int'(wr_err), z >= 24 ? 1 : 0);
  endtask

  initial begin
    int n;
    model_reset();
    #1 reset = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i % 3 == 0) begin
        chk("rst_sseg", int'(sseg), 255);
        chk("rst_digit", int'(digit), 255);
        chk("rst_wr_ready", int'(wr_ready), 1);
      end
    end
    chk("rst_busy", int'(commit_busy), 0);
    chk("rst_frame_start", int'(frame_start), 0);
    chk("rst_wr_err", int'(wr_err), 0);
    reset = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!frame_start && n < 2);
    chk("first_frame_start", int'(frame_start), 1);

    do_write(1, 255, 0);
    do_write(0, 0, 0);
    do_commit();
    wait_ready();
    do_write(23, 128, 1);
    wait_ready();
    do_write(30, 77, 0);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 6; i++) do_write(int'($urandom_range(0, 27)), lvl(), 0);
      do_write(int'($urandom_range(0, 23)), lvl(), 1);
      n = int'($urandom_range(2, 200));
      repeat (n) @(negedge clk);
      if (cnt + 5 < last_e) do_commit();
      if (cnt + 5 < last_e) held_write(int'($urandom_range(0, 23)), lvl());
      else wait_ready();
    end

    n = 0;
    do begin @(negedge clk); n++; end while (!frame_start && n < FR + 10);
    chk("frame_start_seen", int'(frame_start), 1);
    do_commit();
    repeat (20) @(negedge clk);
    @(posedge clk);
    #2;
    if (cnt <= last_e) n_copies--;
    reset = 0;
    model_reset();
    #1;
    chk("midrst_busy", int'(commit_busy), 0);
    chk("midrst_wr_ready", int'(wr_ready), 1);
    chk("midrst_sseg", int'(sseg), 255);
    chk("midrst_digit", int'(digit), 255);
    repeat (5) @(negedge clk);
    reset = 1;
    repeat (2 * FR + 20) @(negedge clk);
    chk("busy_falls", falls, n_copies);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
